// File: rtl/bit_serializer.sv
// bit_serializer
// Parallel-to-serial stimulus stage for the sequence detector's w input.
// A WIDTH-bit word is captured on an accepted Start and shifted out MSB
// first, one bit per enabled clock. Done pulses for one cycle after the
// last bit has been shifted out.
//
// Ports:
//   Clock   rising-edge clock
//   Resetn  synchronous active-low reset
//   Data    parallel word, sampled only on the Start-accept edge
//   Start   load request, accepted only when Ready is high
//   Enable  shift enable; low stalls the stream with all state held
//   Ready   high in idle, Start will be accepted
//   w       serial bit (shift-register MSB)
//   Valid   w carries a word bit that is consumed at this edge
//   Done    one-cycle pulse after the final bit
//   Count   bits remaining, including the bit currently on w
module bit_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic [WIDTH-1:0]             Data,
    input  logic                         Start,
    input  logic                         Enable,
    output logic                         Ready,
    output logic                         w,
    output logic                         Valid,
    output logic                         Done,
    output logic [$clog2(WIDTH+1)-1:0]   Count
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] sr;
    logic [CntW-1:0]  cnt;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= StIdle;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (Start) begin
                        sr    <= Data;
                        cnt   <= CntW'(WIDTH);
                        state <= StShift;
                    end
                end
                StShift: begin
                    // A low Enable freezes everything so no bit is lost.
                    if (Enable) begin
                        sr  <= {sr[WIDTH-2:0], 1'b0};
                        cnt <= cnt - CntW'(1);
                        if (cnt == CntW'(1)) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    sr    <= '0;
                    cnt   <= '0;
                end
                // Unused encoding 2'b11 recovers to idle.
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign Ready = (state == StIdle);
    assign w     = sr[WIDTH-1];
    assign Valid = (state == StShift) & Enable;
    assign Done  = (state == StDone);
    assign Count = cnt;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(WIDTH + 1);

    logic             Clock = 1'b0;
    logic             Resetn;
    logic [WIDTH-1:0] Data;
    logic             Start;
    logic             Enable;
    logic             Ready;
    logic             w;
    logic             Valid;
    logic             Done;
    logic [CW-1:0]    Count;

    bit_serializer #(.WIDTH(WIDTH)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Data   (Data),
        .Start  (Start),
        .Enable (Enable),
        .Ready  (Ready),
        .w      (w),
        .Valid  (Valid),
        .Done   (Done),
        .Count  (Count)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: a queue of bits still to be sent plus a pending Done flag.
    bit m_q[$];
    bit m_done = 1'b0;

    wire [CW+3:0] observed = {Ready, w, Valid, Done, Count};
    localparam logic [CW+3:0] IdleVec = {1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}};

    function automatic logic [CW+3:0] expected();
        logic r, wb, v, d;
        r  = (m_q.size() == 0) && !m_done;
        wb = (m_q.size() > 0) ? m_q[0] : 1'b0;
        v  = (m_q.size() > 0) && Enable;
        d  = m_done;
        return {r, wb, v, d, CW'(m_q.size())};
    endfunction

    task automatic model_edge();
        if (!Resetn) begin
            m_q.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_q.size() > 0) begin
            if (Enable) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (Start) begin
            for (int i = WIDTH - 1; i >= 0; i--) m_q.push_back(Data[i]);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic e,
                         input logic [WIDTH-1:0] d);
        Resetn = r;
        Start  = s;
        Enable = e;
        Data   = d;
        #1;
    endtask

    task automatic advance();
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
        cyc++;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, WIDTH'($urandom));
        advance();
        advance();
        n_checks++;
        if (observed !== IdleVec) begin
            n_errors++;
            $display("FAIL reset_hold got=%b exp=%b", observed, IdleVec);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, WIDTH'($urandom));
            n_checks++;
            if (observed !== IdleVec || observed !== expected()) begin
                n_errors++;
                $display("FAIL reset_idle cycle=%0d got=%b exp=%b", i, observed, IdleVec);
            end
            advance();
        end
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        pat = 8'b1101_1000;
        drive(1'b1, 1'b1, 1'b1, pat);
        advance();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b1, WIDTH'($urandom));
            n_checks++;
            if (w !== pat[7-i] || Valid !== 1'b1 || Count !== CW'(8 - i)
                || observed !== expected()) begin
                n_errors++;
                $display("FAIL basic_bit%0d got w=%b v=%b cnt=%0d exp w=%b v=1 cnt=%0d",
                         i, w, Valid, Count, pat[7-i], 8 - i);
            end
            advance();
        end
        drive(1'b1, 1'b0, 1'b1, '0);
        n_checks++;
        if (Done !== 1'b1 || Valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done got done=%b valid=%b exp done=1 valid=0", Done, Valid);
        end
        advance();
        n_checks++;
        if (observed !== IdleVec) begin
            n_errors++;
            $display("FAIL basic_ready got=%b exp=%b", observed, IdleVec);
        end
    endtask

    task automatic test_stall();
        int stall_left;
        int done_at;
        logic en;
        stall_left = 3;
        done_at    = -1;
        drive(1'b1, 1'b1, 1'b1, 8'b1101_1000);
        advance();
        for (int c = 1; c <= 13; c++) begin
            en = 1'b1;
            if (m_q.size() == 5 && stall_left > 0) begin
                en = 1'b0;
                stall_left--;
            end
            drive(1'b1, 1'b0, en, WIDTH'($urandom));
            n_checks++;
            if (observed !== expected() || (!en && (w !== 1'b1 || Valid !== 1'b0))) begin
                n_errors++;
                $display("FAIL stall cycle=%0d got=%b exp=%b", c, observed, expected());
            end
            if (Done === 1'b1 && done_at < 0) done_at = c;
            advance();
        end
        n_checks++;
        if (done_at != 12) begin
            n_errors++;
            $display("FAIL stall_done_cycle got=%0d exp=12", done_at);
        end
    endtask

    task automatic test_start_held();
        int done_cycles[$];
        for (int c = 0; c < 30; c++) begin
            drive(1'b1, 1'b1, 1'b1, WIDTH'($urandom));
            n_checks++;
            if (observed !== expected()) begin
                n_errors++;
                $display("FAIL start_held cycle=%0d got=%b exp=%b", c, observed, expected());
            end
            if (Done === 1'b1) done_cycles.push_back(c);
            advance();
        end
        n_checks++;
        if (done_cycles.size() != 3) begin
            n_errors++;
            $display("FAIL start_held_words got=%0d exp=3", done_cycles.size());
        end else if (done_cycles[1] - done_cycles[0] != 10
                     || done_cycles[2] - done_cycles[1] != 10) begin
            n_errors++;
            $display("FAIL start_held_spacing got=%0d,%0d exp=10,10",
                     done_cycles[1] - done_cycles[0], done_cycles[2] - done_cycles[1]);
        end
    endtask

    task automatic test_reset_mid();
        int n_done;
        int guard;
        n_done = 0;
        guard  = 0;
        drive(1'b1, 1'b1, 1'b1, WIDTH'($urandom));
        advance();
        while (m_q.size() != 4 && guard < 12) begin
            drive(1'b1, 1'b0, 1'b1, WIDTH'($urandom));
            advance();
            guard++;
        end
        n_checks++;
        if (Count !== CW'(4)) begin
            n_errors++;
            $display("FAIL reset_mid_reach got=%0d exp=4", Count);
        end
        drive(1'b0, 1'b1, 1'b1, WIDTH'($urandom));
        advance();
        drive(1'b1, 1'b0, 1'b1, WIDTH'($urandom));
        n_checks++;
        if (observed !== IdleVec) begin
            n_errors++;
            $display("FAIL reset_mid_idle got=%b exp=%b", observed, IdleVec);
        end
        advance();
        drive(1'b1, 1'b1, 1'b1, WIDTH'($urandom));
        advance();
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, 1'b1, WIDTH'($urandom));
            n_checks++;
            if (observed !== expected()) begin
                n_errors++;
                $display("FAIL reset_mid_word cycle=%0d got=%b exp=%b", c, observed, expected());
            end
            if (Done === 1'b1) n_done++;
            advance();
        end
        n_checks++;
        if (n_done != 1) begin
            n_errors++;
            $display("FAIL reset_mid_done_count got=%0d exp=1", n_done);
        end
    endtask

    // Collect w at every edge where Valid is high, as a Valid-gated consumer would.
    task automatic test_end_to_end();
        logic [7:0] got;
        int nbits;
        logic en;
        got   = '0;
        nbits = 0;
        drive(1'b1, 1'b1, 1'b1, 8'b0110_1111);
        advance();
        for (int c = 0; c < 40 && !(Done === 1'b1); c++) begin
            en = 1'($urandom_range(0, 3) != 0);
            drive(1'b1, 1'b0, en, WIDTH'($urandom));
            if (Valid === 1'b1) begin
                got = {got[6:0], w};
                nbits++;
            end
            advance();
        end
        n_checks++;
        if (nbits != 8 || got !== 8'b0110_1111 || Done !== 1'b1) begin
            n_errors++;
            $display("FAIL end_to_end got=%b bits=%0d done=%b exp=01101111 bits=8 done=1",
                     got, nbits, Done);
        end
        drive(1'b1, 1'b0, 1'b1, '0);
        advance();
    endtask

    task automatic test_random();
        logic r, s, e;
        for (int c = 0; c < 400; c++) begin
            r = 1'($urandom_range(0, 39) != 0);
            s = 1'($urandom_range(0, 2) == 0);
            e = 1'($urandom_range(0, 3) != 0);
            drive(r, s, e, WIDTH'($urandom));
            n_checks++;
            if (observed !== expected()) begin
                n_errors++;
                $display("FAIL random cycle=%0d got=%b exp=%b", c, observed, expected());
            end
            advance();
        end
    endtask

    initial begin
        Resetn = 1'b0;
        Start  = 1'b0;
        Enable = 1'b0;
        Data   = '0;
        test_reset();
        test_basic();
        test_stall();
        test_start_held();
        test_reset_mid();
        test_end_to_end();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
